// File: rtl/ifetch.sv
// Instruction fetch stage: samples the PC, reads instruction memory over a
// req/ack handshake and holds the fetched word in a one-entry IR for decode.
//
// Ports:
//   clock, n_rst        rising-edge clock, async active-low reset
//   pc / pc_step        PC value in, PC advance enable out
//   flush               taken-branch pulse, discards in-flight/held fetch
//   mem_req/mem_addr    registered read request to instruction memory
//   mem_ack/mem_rdata   one-cycle read completion with data
//   ir/ir_pc/ir_valid   instruction register, its address, valid flag
//   ir_ready            decoder accepts ir this cycle
module ifetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_step,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DROP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              req_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] ir_nx;
    logic [ADDR_W-1:0] ir_pc_nx;
    logic              valid_nx;
    logic              step_nx;

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            pc_step  <= 1'b0;
        end else begin
            state    <= state_nx;
            mem_req  <= req_nx;
            mem_addr <= addr_nx;
            ir       <= ir_nx;
            ir_pc    <= ir_pc_nx;
            ir_valid <= valid_nx;
            pc_step  <= step_nx;
        end
    end

    always_comb begin
        state_nx = state;
        req_nx   = mem_req;
        addr_nx  = mem_addr;
        ir_nx    = ir;
        ir_pc_nx = ir_pc;
        valid_nx = ir_valid;
        step_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                // A flush here means pc is being reloaded this edge;
                // wait one edge so the request uses the branch target.
                if (!flush) begin
                    req_nx   = 1'b1;
                    addr_nx  = pc;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    req_nx = 1'b0;
                    if (flush) begin
                        state_nx = IDLE;
                    end else begin
                        ir_nx    = mem_rdata;
                        ir_pc_nx = mem_addr;
                        valid_nx = 1'b1;
                        step_nx  = 1'b1;
                        state_nx = HOLD;
                    end
                end else if (flush) begin
                    // Request stays up; its data is stale once it lands.
                    state_nx = DROP;
                end
            end
            HOLD: begin
                if (flush || ir_ready) begin
                    valid_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    req_nx   = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: cycle-by-cycle vector table plus hand-written
// asynchronous reset sequences.
module tb_ifetch;

    logic        clock = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] pc = '0;
    logic        pc_step;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    ifetch #(.DATA_W(16), .ADDR_W(16)) dut (
        .clock     (clock),
        .n_rst     (n_rst),
        .pc        (pc),
        .pc_step   (pc_step),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready)
    );

    typedef struct {
        logic        fl;
        logic        ack;
        logic        rdy;
        logic [15:0] pcv;
        logic [15:0] rd;
        logic        req;
        logic [15:0] addr;
        logic        iv;
        logic [15:0] irv;
        logic [15:0] irpc;
        logic        step;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic fl, input logic ack, input logic rdy,
                       input logic [15:0] pcv, input logic [15:0] rd,
                       input logic req, input logic [15:0] addr,
                       input logic iv, input logic [15:0] irv,
                       input logic [15:0] irpc, input logic step);
        vec_t v;
        v.fl = fl; v.ack = ack; v.rdy = rdy; v.pcv = pcv; v.rd = rd;
        v.req = req; v.addr = addr; v.iv = iv; v.irv = irv;
        v.irpc = irpc; v.step = step;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx,
                           input logic req, input logic [15:0] addr,
                           input logic iv, input logic [15:0] irv,
                           input logic [15:0] irpc, input logic step);
        chk({tag, ".mem_req"}, idx, 32'(mem_req), 32'(req));
        chk({tag, ".mem_addr"}, idx, 32'(mem_addr), 32'(addr));
        chk({tag, ".ir_valid"}, idx, 32'(ir_valid), 32'(iv));
        chk({tag, ".ir"}, idx, 32'(ir), 32'(irv));
        chk({tag, ".ir_pc"}, idx, 32'(ir_pc), 32'(irpc));
        chk({tag, ".pc_step"}, idx, 32'(pc_step), 32'(step));
    endtask

    task automatic drive(input logic fl, input logic ack, input logic rdy,
                         input logic [15:0] pcv, input logic [15:0] rd);
        flush = fl;
        mem_ack = ack;
        ir_ready = rdy;
        pc = pcv;
        mem_rdata = rd;
    endtask

    initial begin
        // fl ack rdy pc rd | req addr iv ir ir_pc step
        // reset release, 2-cycle memory, ready high
        add(0,0,1,16'h0000,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000, 0);
        add(0,0,1,16'h0000,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000, 0);
        add(0,1,1,16'h0000,16'h1234, 0,16'h0000, 1,16'h1234,16'h0000, 1);
        add(0,0,1,16'h0000,16'h0000, 0,16'h0000, 0,16'h1234,16'h0000, 0);
        // backpressure: ready low for 5 cycles, stray ack ignored
        add(0,0,0,16'h0001,16'h0000, 1,16'h0001, 0,16'h1234,16'h0000, 0);
        add(0,1,0,16'h0001,16'h5555, 0,16'h0001, 1,16'h5555,16'h0001, 1);
        add(0,0,0,16'h0001,16'h0000, 0,16'h0001, 1,16'h5555,16'h0001, 0);
        add(0,0,0,16'h0002,16'h0000, 0,16'h0001, 1,16'h5555,16'h0001, 0);
        add(0,1,0,16'h0002,16'hFFFF, 0,16'h0001, 1,16'h5555,16'h0001, 0);
        add(0,0,0,16'h0002,16'h0000, 0,16'h0001, 1,16'h5555,16'h0001, 0);
        add(0,0,0,16'h0002,16'h0000, 0,16'h0001, 1,16'h5555,16'h0001, 0);
        add(0,0,1,16'h0002,16'h0000, 0,16'h0001, 0,16'h5555,16'h0001, 0);
        add(0,0,0,16'h0002,16'h0000, 1,16'h0002, 0,16'h5555,16'h0001, 0);
        add(0,1,1,16'h0002,16'h2222, 0,16'h0002, 1,16'h2222,16'h0002, 1);
        add(1,0,1,16'h0002,16'h0000, 0,16'h0002, 0,16'h2222,16'h0002, 0);
        // zero-wait stream from 0x0010
        add(0,0,1,16'h0010,16'h0000, 1,16'h0010, 0,16'h2222,16'h0002, 0);
        add(0,1,1,16'h0010,16'hA010, 0,16'h0010, 1,16'hA010,16'h0010, 1);
        add(0,0,1,16'h0010,16'h0000, 0,16'h0010, 0,16'hA010,16'h0010, 0);
        add(0,0,1,16'h0011,16'h0000, 1,16'h0011, 0,16'hA010,16'h0010, 0);
        add(0,1,1,16'h0011,16'hA011, 0,16'h0011, 1,16'hA011,16'h0011, 1);
        add(0,0,1,16'h0011,16'h0000, 0,16'h0011, 0,16'hA011,16'h0011, 0);
        add(0,0,1,16'h0012,16'h0000, 1,16'h0012, 0,16'hA011,16'h0011, 0);
        add(0,1,1,16'h0012,16'hA012, 0,16'h0012, 1,16'hA012,16'h0012, 1);
        add(0,0,1,16'h0012,16'h0000, 0,16'h0012, 0,16'hA012,16'h0012, 0);
        // flush with request pending, stale ack two cycles later
        add(0,0,1,16'h0013,16'h0000, 1,16'h0013, 0,16'hA012,16'h0012, 0);
        add(1,0,1,16'h0013,16'h0000, 1,16'h0013, 0,16'hA012,16'h0012, 0);
        add(0,0,1,16'h0040,16'h0000, 1,16'h0013, 0,16'hA012,16'h0012, 0);
        add(0,1,1,16'h0040,16'hDEAD, 0,16'h0013, 0,16'hA012,16'h0012, 0);
        add(0,0,1,16'h0040,16'h0000, 1,16'h0040, 0,16'hA012,16'h0012, 0);
        // flush coincident with ack
        add(1,1,1,16'h0040,16'hBEEF, 0,16'h0040, 0,16'hA012,16'h0012, 0);
        add(0,0,0,16'h0080,16'h0000, 1,16'h0080, 0,16'hA012,16'h0012, 0);
        // flush while holding
        add(0,1,0,16'h0080,16'hC080, 0,16'h0080, 1,16'hC080,16'h0080, 1);
        add(1,0,0,16'h0080,16'h0000, 0,16'h0080, 0,16'hC080,16'h0080, 0);
        add(0,0,1,16'h0090,16'h0000, 1,16'h0090, 0,16'hC080,16'h0080, 0);
        // flush while idle
        add(0,1,1,16'h0090,16'hD090, 0,16'h0090, 1,16'hD090,16'h0090, 1);
        add(0,0,1,16'h0090,16'h0000, 0,16'h0090, 0,16'hD090,16'h0090, 0);
        add(1,0,1,16'h0091,16'h0000, 0,16'h0090, 0,16'hD090,16'h0090, 0);
        add(0,0,1,16'h00A0,16'h0000, 1,16'h00A0, 0,16'hD090,16'h0090, 0);
        // top-of-memory address and wrap to zero
        add(0,1,1,16'h00A0,16'hE0A0, 0,16'h00A0, 1,16'hE0A0,16'h00A0, 1);
        add(1,0,1,16'h00A0,16'h0000, 0,16'h00A0, 0,16'hE0A0,16'h00A0, 0);
        add(0,0,1,16'hFFFF,16'h0000, 1,16'hFFFF, 0,16'hE0A0,16'h00A0, 0);
        add(0,1,1,16'hFFFF,16'hF00F, 0,16'hFFFF, 1,16'hF00F,16'hFFFF, 1);
        add(0,0,1,16'hFFFF,16'h0000, 0,16'hFFFF, 0,16'hF00F,16'hFFFF, 0);
        add(0,0,1,16'h0000,16'h0000, 1,16'h0000, 0,16'hF00F,16'hFFFF, 0);

        // reset state
        repeat (2) @(posedge clock);
        #1 chk_all("reset", 0, 0, 16'h0, 0, 16'h0, 16'h0, 0);
        @(negedge clock);
        n_rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            if (i > 0) @(negedge clock);
            drive(vq[i].fl, vq[i].ack, vq[i].rdy, vq[i].pcv, vq[i].rd);
            @(posedge clock);
            #1 chk_all("vec", i, vq[i].req, vq[i].addr, vq[i].iv,
                       vq[i].irv, vq[i].irpc, vq[i].step);
        end

        // reset mid-REQ: outputs clear without a clock edge
        @(negedge clock);
        drive(0, 0, 1, 16'h0000, 16'h0000);
        #2 n_rst = 1'b0;
        #1 chk_all("rst_req", 0, 0, 16'h0, 0, 16'h0, 16'h0, 0);
        drive(0, 1, 1, 16'h0033, 16'h7777);
        @(posedge clock);
        #1 chk_all("rst_hold_edge", 0, 0, 16'h0, 0, 16'h0, 16'h0, 0);
        @(negedge clock);
        drive(0, 0, 0, 16'h0000, 16'h0000);
        n_rst = 1'b1;
        @(posedge clock);
        #1 chk_all("rst_req_rel", 0, 1, 16'h0000, 0, 16'h0, 16'h0, 0);
        @(negedge clock);
        drive(0, 1, 0, 16'h0000, 16'h4321);
        @(posedge clock);
        #1 chk_all("rst_hold_pre", 0, 0, 16'h0000, 1, 16'h4321, 16'h0, 1);
        @(negedge clock);
        drive(0, 0, 0, 16'h0000, 16'h0000);
        @(posedge clock);
        // reset mid-HOLD
        #3 n_rst = 1'b0;
        #1 chk_all("rst_hold", 0, 0, 16'h0, 0, 16'h0, 16'h0, 0);
        @(negedge clock);
        drive(0, 0, 1, 16'h0000, 16'h0000);
        n_rst = 1'b1;
        @(posedge clock);
        #1 chk_all("rst_hold_rel", 0, 1, 16'h0000, 0, 16'h0, 16'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
